decode_writeback: RTL and testbench

- SEQ-processor decode/write-back stage, directly downstream of the fetch stage.
- Consumes icode, rA and rB, plus the execute/memory results valE, valM and cnd.
- Holds the 15-entry × 64-bit architectural register file; produces valA and valB for execute.
- Commits dstE/dstM writes on the clock edge that retires the instruction.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/regfile_2r2w.sv | 58 +++++
 rtl/decode_writeback.sv | 124 ++++++++++++
 tb/tb_decode_writeback.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: icodes, register specifiers, data width.
package y86_pkg;

  localparam int DEF_DATA_W = 64;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [3:0] {
    I_HALT  = 4'h0,
    I_NOP   = 4'h1,
    I_RRMOV = 4'h2,
    I_IRMOV = 4'h3,
    I_RMMOV = 4'h4,
    I_MRMOV = 4'h5,
    I_OPQ   = 4'h6,
    I_JXX   = 4'h7,
    I_CALL  = 4'h8,
    I_RET   = 4'h9,
    I_PUSHQ = 4'hA,
    I_POPQ  = 4'hB
  } icode_e;

endpackage

// File: rtl/regfile_2r2w.sv
// 15-entry register file: two async reads, debug read, two writes.
// Index F reads as zero; the M write port wins on a same-index collision.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] STACK_INIT = DATA_W'(1000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ra_a_i,
  input  logic [3:0]        ra_b_i,
  input  logic [3:0]        ra_d_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  output logic [DATA_W-1:0] rd_d_o,
  input  logic              we_e_i,
  input  logic [3:0]        wa_e_i,
  input  logic [DATA_W-1:0] wd_e_i,
  input  logic              we_m_i,
  input  logic [3:0]        wa_m_i,
  input  logic [DATA_W-1:0] wd_m_i
);

  logic [DATA_W-1:0] reg_q [15];
  logic [DATA_W-1:0] reg_d [15];

  always_comb begin
    rd_a_o = '0;
    rd_b_o = '0;
    rd_d_o = '0;
    for (int i = 0; i < 15; i++) begin
      if (ra_a_i == 4'(i)) rd_a_o = reg_q[i];
      if (ra_b_i == 4'(i)) rd_b_o = reg_q[i];
      if (ra_d_i == 4'(i)) rd_d_o = reg_q[i];
    end
  end

  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < 15; i++) begin
      if (we_m_i && wa_m_i == 4'(i))
        reg_d[i] = wd_m_i;
      else if (we_e_i && wa_e_i == 4'(i))
        reg_d[i] = wd_e_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++)
        reg_q[i] <= (4'(i) == RSP) ? STACK_INIT : '0;
    end else begin
      reg_q <= reg_d;
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode/write-back stage: source/destination decode, register file
// access, write gating and a count of committed register writes.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] STACK_INIT = DATA_W'(1000),
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);

  logic             wr_e;
  logic             wr_m;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      I_RRMOV: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      I_IRMOV: dstE = rB;
      I_RMMOV: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOV: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RSP;
        dstE = RSP;
      end
      I_RET: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = RSP;
        dstE = RSP;
      end
      I_POPQ: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  assign wr_e = wb_en && (dstE != RNONE);
  assign wr_m = wb_en && (dstM != RNONE);

  regfile_2r2w #(
    .DATA_W     (DATA_W),
    .STACK_INIT (STACK_INIT)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra_a_i (srcA),
    .ra_b_i (srcB),
    .ra_d_i (dbg_sel),
    .rd_a_o (valA),
    .rd_b_o (valB),
    .rd_d_o (dbg_data),
    .we_e_i (wr_e),
    .wa_e_i (dstE),
    .wd_e_i (valE),
    .we_m_i (wr_m),
    .wa_m_i (dstM),
    .wd_m_i (valM)
  );

  // A dual-write instruction still retires as one commit.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_e || wr_m) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign wb_count = cnt_q;

  a_dst_known: assert property (
    @(posedge clk) disable iff (!rst_n)
    wb_en |-> !$isunknown({dstE, dstM})
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback with a 4-bit commit counter.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, rA, rB, dbg_sel;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, dbg_data;
  logic [3:0]  wb_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_writeback #(
    .DATA_W     (64),
    .STACK_INIT (64'd1000),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .icode    (icode),
    .rA       (rA),
    .rB       (rB),
    .cnd      (cnd),
    .valE     (valE),
    .valM     (valM),
    .wb_en    (wb_en),
    .srcA     (srcA),
    .srcB     (srcB),
    .dstE     (dstE),
    .dstM     (dstM),
    .valA     (valA),
    .valB     (valB),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .wb_count (wb_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] idx,
                        input logic [63:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic set(input logic [3:0] ic, input logic [3:0] a,
                     input logic [3:0] b, input logic c,
                     input logic [63:0] e, input logic [63:0] m,
                     input logic en);
    icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; wb_en = en;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    dbg_sel = 4'h0;
    set(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    #12;
    for (int i = 0; i < 15; i++)
      rd_reg($sformatf("rst_reg%0d", i), 4'(i),
             (i == 4) ? 64'd1000 : 64'd0);
    rd_reg("rst_regF", 4'hF, 64'd0);
    chk("rst_cnt", 64'(wb_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // irmovq $0x55, %rdx
    set(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 1'b1);
    chk("irmov_srcA", 64'(srcA), 64'hF);
    chk("irmov_srcB", 64'(srcB), 64'hF);
    chk("irmov_dstE", 64'(dstE), 64'h2);
    chk("irmov_dstM", 64'(dstM), 64'hF);
    tick();
    rd_reg("irmov_reg2", 4'h2, 64'h55);
    chk("irmov_cnt", 64'(wb_count), 64'd1);

    // cmovXX not taken
    set(4'h2, 4'h2, 4'h3, 1'b0, 64'h77, 64'h0, 1'b1);
    chk("cmov0_srcA", 64'(srcA), 64'h2);
    chk("cmov0_valA", valA, 64'h55);
    chk("cmov0_dstE", 64'(dstE), 64'hF);
    tick();
    rd_reg("cmov0_reg3", 4'h3, 64'h0);
    chk("cmov0_cnt", 64'(wb_count), 64'd1);

    // cmovXX taken
    set(4'h2, 4'h2, 4'h3, 1'b1, 64'h55, 64'h0, 1'b1);
    chk("cmov1_dstE", 64'(dstE), 64'h3);
    tick();
    rd_reg("cmov1_reg3", 4'h3, 64'h55);
    chk("cmov1_cnt", 64'(wb_count), 64'd2);

    // popq %rsp: M write beats E write, one commit
    set(4'hB, 4'h4, 4'hF, 1'b0, 64'd1008, 64'hABCD, 1'b1);
    chk("popq_srcA", 64'(srcA), 64'h4);
    chk("popq_srcB", 64'(srcB), 64'h4);
    chk("popq_dstE", 64'(dstE), 64'h4);
    chk("popq_dstM", 64'(dstM), 64'h4);
    chk("popq_valA", valA, 64'd1000);
    tick();
    rd_reg("popq_reg4", 4'h4, 64'hABCD);
    chk("popq_cnt", 64'(wb_count), 64'd3);

    // pushq %rdx; valB shows pre-edge %rsp until the edge
    set(4'hA, 4'h2, 4'hF, 1'b0, 64'hABC5, 64'h0, 1'b1);
    chk("push_srcA", 64'(srcA), 64'h2);
    chk("push_srcB", 64'(srcB), 64'h4);
    chk("push_dstE", 64'(dstE), 64'h4);
    chk("push_dstM", 64'(dstM), 64'hF);
    chk("push_valA", valA, 64'h55);
    chk("push_valB_pre", valB, 64'hABCD);
    tick();
    chk("push_valB_post", valB, 64'hABC5);
    chk("push_cnt", 64'(wb_count), 64'd4);

    // mrmovq -> %rsi
    set(4'h5, 4'h6, 4'h2, 1'b0, 64'h0, 64'h99, 1'b1);
    chk("mrmov_srcA", 64'(srcA), 64'hF);
    chk("mrmov_srcB", 64'(srcB), 64'h2);
    chk("mrmov_dstE", 64'(dstE), 64'hF);
    chk("mrmov_dstM", 64'(dstM), 64'h6);
    chk("mrmov_valB", valB, 64'h55);
    tick();
    rd_reg("mrmov_reg6", 4'h6, 64'h99);
    chk("mrmov_cnt", 64'(wb_count), 64'd5);

    // OPq with wb_en low: decode live, no commit
    set(4'h6, 4'h3, 4'h2, 1'b0, 64'h7, 64'h0, 1'b0);
    chk("opq_dstE", 64'(dstE), 64'h2);
    chk("opq_valA", valA, 64'h55);
    tick();
    rd_reg("opq_reg2", 4'h2, 64'h55);
    chk("opq_cnt", 64'(wb_count), 64'd5);

    // halt with wb_en high: nothing to write
    set(4'h0, 4'h2, 4'h2, 1'b1, 64'h11, 64'h22, 1'b1);
    chk("halt_dstE", 64'(dstE), 64'hF);
    chk("halt_dstM", 64'(dstM), 64'hF);
    tick();
    rd_reg("halt_reg2", 4'h2, 64'h55);
    chk("halt_cnt", 64'(wb_count), 64'd5);

    // jXX and unused icode decode to all-RNONE
    set(4'h7, 4'h2, 4'h3, 1'b1, 64'h0, 64'h0, 1'b0);
    chk("jxx_idx", 64'({srcA, srcB, dstE, dstM}), 64'hFFFF);
    set(4'hC, 4'h2, 4'h3, 1'b1, 64'h0, 64'h0, 1'b0);
    chk("icC_idx", 64'({srcA, srcB, dstE, dstM}), 64'hFFFF);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    rd_reg("arst_reg2", 4'h2, 64'h0);
    rd_reg("arst_reg4", 4'h4, 64'd1000);
    rd_reg("arst_reg6", 4'h6, 64'h0);
    chk("arst_cnt", 64'(wb_count), 64'd0);
    set(4'h3, 4'hF, 4'h2, 1'b0, 64'h66, 64'h0, 1'b1);
    chk("inrst_dstE", 64'(dstE), 64'h2);
    tick();
    rd_reg("inrst_reg2", 4'h2, 64'h0);
    chk("inrst_cnt", 64'(wb_count), 64'd0);
    rst_n = 1'b1;

    // counter wrap: 16 commits into reg1
    for (int i = 1; i <= 16; i++) begin
      set(4'h3, 4'hF, 4'h1, 1'b0, 64'(i), 64'h0, 1'b1);
      tick();
      if (i == 1)  chk("first_cnt", 64'(wb_count), 64'd1);
      if (i == 15) chk("wrap_cnt15", 64'(wb_count), 64'd15);
    end
    chk("wrap_cnt0", 64'(wb_count), 64'd0);
    rd_reg("wrap_reg1", 4'h1, 64'd16);
    rd_reg("dbg_F", 4'hF, 64'd0);

    set(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1);
    tick();
    chk("halt2_cnt", 64'(wb_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
